// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx
//  Description : PS/2 device-to-host frame receiver. Synchronises and
//                glitch-filters the raw PS/2 clock and data pins and
//                deserialises 11-bit frames into bytes. It emits one-cycle
//                byte and error strobes. It never drives the PS/2 lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err_parity,
    output logic       rx_err_stop,
    output logic       rx_err_timeout,
    output logic       rx_busy
);

    localparam int c_fcnt_w = $clog2(FILTER_LEN + 1);
    localparam int c_tcnt_w = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FILTER_LEN - 1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Synchroniser flops; idle PS/2 lines are high, so they reset to 1.
    logic                clk_meta_q, clk_meta_d;
    logic                clk_sync_q, clk_sync_d;
    logic                data_meta_q, data_meta_d;
    logic                data_sync_q, data_sync_d;

    // Clock glitch filter and registered edge detection.
    logic                filt_clk_q, filt_clk_d;
    logic                filt_prev_q, filt_prev_d;
    logic [c_fcnt_w-1:0] fcnt_q, fcnt_d;
    logic                fall;

    // Frame state.
    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                par_ok_q, par_ok_d;
    logic [c_tcnt_w-1:0] tcnt_q, tcnt_d;

    // Registered outputs.
    logic [7:0]          rx_byte_q, rx_byte_d;
    logic                rx_valid_q, rx_valid_d;
    logic                err_par_q, err_par_d;
    logic                err_stop_q, err_stop_d;
    logic                err_to_q, err_to_d;
    logic                busy_q, busy_d;

    // Two-flop synchronisers, then filter the clock: the filtered value only
    // follows the synced pin after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_meta_d  = ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data_in;
        data_sync_d = data_meta_q;

        filt_clk_d  = filt_clk_q;
        fcnt_d      = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (fcnt_q == c_fcnt_last) begin
                filt_clk_d = clk_sync_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        filt_prev_d = filt_clk_q;
    end

    assign fall = filt_prev_q & ~filt_clk_q;

    // Frame FSM: advances on filtered clock falls; an inactivity timeout
    // aborts a partial frame. A fall in the same cycle takes priority.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_ok_d   = par_ok_q;
        tcnt_d     = tcnt_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        err_par_d  = 1'b0;
        err_stop_d = 1'b0;
        err_to_d   = 1'b0;

        if ((state_q == ST_IDLE) || fall) begin
            tcnt_d = '0;
        end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    // A fall with data high is a spurious edge; ignore it.
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {data_sync_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = (^shreg_q) ^ data_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (par_ok_q && data_sync_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shreg_q;
                    end
                    err_par_d  = ~par_ok_q;
                    err_stop_d = ~data_sync_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if ((state_q != ST_IDLE) && (tcnt_q == c_tcnt_last)) begin
            state_d  = ST_IDLE;
            err_to_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State register for all flops; an asynchronous reset discards any
    // partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            par_ok_q    <= 1'b0;
            tcnt_q      <= '0;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            err_par_q   <= 1'b0;
            err_stop_q  <= 1'b0;
            err_to_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_prev_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_ok_q    <= par_ok_d;
            tcnt_q      <= tcnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            err_par_q   <= err_par_d;
            err_stop_q  <= err_stop_d;
            err_to_q    <= err_to_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_byte        = rx_byte_q;
    assign rx_valid       = rx_valid_q;
    assign rx_err_parity  = err_par_q;
    assign rx_err_stop    = err_stop_q;
    assign rx_err_timeout = err_to_q;
    assign rx_busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_frame_rx
//  Description : Self-checking bench for ps2_frame_rx. Drives PS/2 frames
//                bit by bit. Pulses are counted by a monitor and compared
//                against outcomes derived from the frame rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_frame_rx;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_err_parity, rx_err_stop, rx_err_timeout, rx_busy;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk_in     (ps2_clk_in),
        .ps2_data_in    (ps2_data_in),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .rx_err_parity  (rx_err_parity),
        .rx_err_stop    (rx_err_stop),
        .rx_err_timeout (rx_err_timeout),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state
    int         m_valid = 0, m_perr = 0, m_serr = 0, m_to = 0, m_both = 0;
    int         m_conflict = 0, m_byte_chg = 0;
    logic [7:0] prev_byte = 8'd0;
    logic [7:0] got_q[$];
    bit         gap_en = 1'b0, gap_seen = 1'b0;
    int         gap_run = 0, max_gap = 0;
    logic [7:0] exp_byte = 8'd0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                m_valid++;
                got_q.push_back(rx_byte);
            end
            if (rx_err_parity) m_perr++;
            if (rx_err_stop) m_serr++;
            if (rx_err_timeout) m_to++;
            if (rx_err_parity && rx_err_stop) m_both++;
            if (rx_valid && (rx_err_parity || rx_err_stop || rx_err_timeout)) m_conflict++;
            if (!rx_valid && (rx_byte !== prev_byte)) m_byte_chg++;
        end
        prev_byte = rx_byte;
        if (gap_en) begin
            if (rx_busy) begin
                if (gap_seen && gap_run > max_gap) max_gap = gap_run;
                gap_seen = 1'b1;
                gap_run  = 0;
            end else if (gap_seen) begin
                gap_run++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        m_valid = 0; m_perr = 0; m_serr = 0; m_to = 0; m_both = 0;
        got_q.delete();
    endtask

    // One PS/2 bit: data set while clock high, then a low half period.
    // Optional short low glitch in the middle of the high phase.
    task automatic put_bit(input bit v, input bit glitch);
        ps2_data_in = v;
        if (glitch) begin
            wait_cyc(HALF / 2);
            ps2_clk_in = 1'b0;
            wait_cyc(FL - 1);
            ps2_clk_in = 1'b1;
            wait_cyc(HALF - HALF / 2 - (FL - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk_in = 1'b0;
        wait_cyc(HALF);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
        bit p;
        p = ~(^b) ^ bad_par;
        put_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) put_bit(b[i], glitch);
        put_bit(p, glitch);
        put_bit(stop, glitch);
        ps2_data_in = 1'b1;
    endtask

    // Reference outcome of one completed frame.
    task automatic expect_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit stop);
        bit good;
        good = !bad_par && stop;
        wait_cyc(10);
        if (good) exp_byte = b;
        check({tag, "_valid"}, m_valid, {31'd0, good});
        check({tag, "_perr"}, m_perr, {31'd0, bad_par});
        check({tag, "_serr"}, m_serr, {31'd0, !stop});
        check({tag, "_both"}, m_both, {31'd0, bad_par && !stop});
        check({tag, "_tout"}, m_to, 0);
        check({tag, "_byte"}, rx_byte, exp_byte);
        check({tag, "_busy"}, rx_busy, 0);
        clear_mon();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0, b1, rb;
        bit         bp, st, gl;

        // Reset values
        wait_cyc(5);
        check("rst_byte", rx_byte, 0);
        check("rst_pulses", {rx_valid, rx_err_parity, rx_err_stop, rx_err_timeout}, 0);
        check("rst_busy", rx_busy, 0);
        rst = 1'b0;
        wait_cyc(10);
        clear_mon();

        // Single good frame
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        expect_frame("t1", 8'h1C, 1'b0, 1'b1);

        // Back-to-back frames
        gap_en = 1'b1; gap_seen = 1'b0; gap_run = 0; max_gap = 0;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_cyc(10);
        gap_en = 1'b0;
        b0 = (got_q.size() > 0) ? got_q[0] : 8'h00;
        b1 = (got_q.size() > 1) ? got_q[1] : 8'h00;
        check("t2_count", got_q.size(), 2);
        check("t2_first", b0, 8'hF0);
        check("t2_second", b1, 8'h1C);
        check("t2_errs", m_perr + m_serr + m_to, 0);
        check("t2_gap_ok", (max_gap > 0) && (max_gap <= 2 * HALF), 1);
        exp_byte = 8'h1C;
        clear_mon();

        // Parity error, stop error, both
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        expect_frame("t3", 8'h22, 1'b1, 1'b1);
        send_frame(8'h16, 1'b0, 1'b0, 1'b0);
        expect_frame("t4a", 8'h16, 1'b0, 1'b0);
        send_frame(8'h16, 1'b1, 1'b0, 1'b0);
        expect_frame("t4b", 8'h16, 1'b1, 1'b0);

        // Glitch while idle with data low must not start a frame
        ps2_data_in = 1'b0;
        ps2_clk_in  = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk_in  = 1'b1;
        wait_cyc(FL + 6);
        check("t5_idle_busy", rx_busy, 0);
        ps2_data_in = 1'b1;
        wait_cyc(HALF);
        send_frame(8'h1D, 1'b0, 1'b1, 1'b1);
        expect_frame("t5", 8'h1D, 1'b0, 1'b1);

        // Timeout after start plus five data bits
        put_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) put_bit(i[0], 1'b0);
        ps2_data_in = 1'b1;
        check("t6_busy_mid", rx_busy, 1);
        wait_cyc(TO + 50);
        check("t6_tout", m_to, 1);
        check("t6_valid", m_valid, 0);
        check("t6_busy", rx_busy, 0);
        check("t6_byte", rx_byte, exp_byte);
        clear_mon();
        send_frame(8'h24, 1'b0, 1'b1, 1'b0);
        expect_frame("t6n", 8'h24, 1'b0, 1'b1);

        // Reset mid-frame
        put_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) put_bit(1'b1, 1'b0);
        rst = 1'b1;
        wait_cyc(3);
        check("t7_rst_byte", rx_byte, 0);
        check("t7_rst_busy", rx_busy, 0);
        check("t7_rst_pulses", {rx_valid, rx_err_parity, rx_err_stop, rx_err_timeout}, 0);
        rst = 1'b0;
        exp_byte = 8'h00;
        wait_cyc(TO + 20);
        check("t7_no_pulse", m_valid + m_perr + m_serr + m_to, 0);
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        expect_frame("t7n", 8'h5A, 1'b0, 1'b1);

        // Randomised frames
        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) != 0);
            gl = ($urandom_range(0, 2) == 0);
            send_frame(rb, bp, st, gl);
            expect_frame($sformatf("rnd%0d", k), rb, bp, st);
        end

        check("never_valid_with_err", m_conflict, 0);
        check("byte_only_with_valid", m_byte_chg, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
